setuphold_stim_gen: RTL and testbench
=====================================

// Module: setuphold_stim_gen
// PURPOSE
// - Synchronous stimulus source for the scan-flop timing-check checkers (CP/D/TI/TE with notifier).
// - Derives a strobe clock CPO from the fast tick clock CP and moves D, TI and TE at programmed signed offsets from each CPO rising edge.
//   Negative offset = setup side, positive offset = hold side.
// - Counts notifier toggles returned by the checker under test.
// PARAMETERS
// - PERIOD   64  CP ticks per CPO period (even, >=8); CPO rises at EDGE=PERIOD/2.
// - OFFW     8   width of signed offset inputs.
// - CNTW     16  width of frame and violation counters.
// PORTS
// - CP        in   1     tick clock; only clock, all logic on posedge CP.
// - RST       in   1     synchronous, active-high reset.
// - start     in   1     1-cycle pulse; begins a run when idle.
// - abort     in   1     terminates a run; takes priority over start.
// - nframes   in   CNTW  CPO periods per run; sampled at start.
// - d_off     in   OFFW  signed D offset in ticks from EDGE; sampled at start.
// - ti_off    in   OFFW  signed TI offset in ticks from EDGE; sampled at start.
// - te_off    in   OFFW  signed TE offset in ticks from EDGE; sampled at start.
// - notifier  in   1     checker notifier; any level change = one violation.
// - cpo       out  1     generated strobe clock.
// - d_o       out  1     D stimulus.
// - ti_o      out  1     TI stimulus.
// - te_o      out  1     TE stimulus.
// - busy      out  1     high in ARM and RUN.
// - done      out  1     1-cycle pulse at run end, normal or aborted.
// - viol_cnt  out  CNTW  saturating violation count; cleared at start.
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, tick=0, frame=0, notifier history = current notifier.
// - FSM states: IDLE -> ARM -> RUN -> DONE -> IDLE.
//   - IDLE->ARM on start: latch cfg, clear viol_cnt.
//   - ARM lasts 1 cycle; loads tick=0, frame=0.
//   - ARM->DONE directly if nframes==0.
//   - RUN->DONE when tick==PERIOD-1 and frame==nframes-1.
//   - DONE lasts 1 cycle; done=1 there only.
// - Offsets are clamped at latch time to [-(EDGE-1), PERIOD-1-EDGE].
//   Every programmed event therefore falls inside its own frame.
// - RUN tick counter: 0..PERIOD-1, wraps to 0 and increments frame.
// - cpo is registered: 1 for tick in [EDGE, PERIOD-1], else 0.
// - d_o, ti_o, te_o each toggle once per frame, registered, in the cycle tick==EDGE+off.
//   Initial value at ARM: d_o=0, ti_o=1, te_o=0.
// - Equal offsets: the affected signals toggle in the same cycle.
// - start while busy: ignored; cfg inputs are not re-sampled.
// - abort in ARM or RUN: next cycle enters DONE with cpo/d_o/ti_o/te_o forced to 0; viol_cnt held.
// - abort in IDLE or DONE: no effect.
// - Violation detect: notifier is registered once; prev!=curr in ARM/RUN/DONE increments viol_cnt.
//   viol_cnt saturates at all-ones. Toggles in IDLE are not counted.
// - viol_cnt holds its value after DONE until the next start.
// - Reset mid-run: immediate return to reset state next cycle; no done pulse.
// STRUCTURE
// - Shared package: FSM state enum (IDLE/ARM/RUN/DONE) and an offset clamp function.
//   The same package is used by the checker benches.
// - One sub-module, stim_edge_sched: one instance per stimulus line.
//   - Inputs: tick, clamped offset, load, clear.
//   - Output: registered toggling line.
//   Top holds the FSM, counters, cpo and violation counter.
// TESTING
// 1. PERIOD=64, nframes=3, d_off=-10, ti_off=20, te_off=-4, notifier static.
//    -> d_o toggles at tick 22, ti_o at 52, te_o at 28 in each frame.
//    -> cpo rises at tick 32 three times; done after 192+2 cycles; viol_cnt=0.
// 2. d_off=-100, ti_off=+100.
//    -> clamped; d_o toggles at tick 1, ti_o at tick 63.
// 3. notifier toggles 5 times during RUN, 2 times while IDLE.
//    -> viol_cnt=5; CNTW=3 with 9 toggles -> viol_cnt=7.
// 4. abort at frame 1, tick 40.
//    -> next cycle DONE, done=1, all stimulus 0.
//    -> start pulse during that run was ignored.
// 5. nframes=0.
//    -> busy 1 cycle, done on the 2nd cycle after start, cpo never rises.
// 6. RST asserted at frame 2, tick 10.
//    -> next cycle all outputs 0, FSM IDLE, no done pulse.

Source files
------------

// File: rtl/setuphold_stim_gen_pkg.sv
// rtl/setuphold_stim_gen_pkg.sv - shared FSM state type and offset clamp for the setup/hold stimulus generator
package setuphold_stim_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } stim_state_e;

    // Keeps an event strictly inside its own frame: never on tick 0, never past PERIOD-1.
    function automatic int clamp_off(input int off, input int period);
        int half;
        half = period / 2;
        if (off < -(half - 1)) return -(half - 1);
        if (off > period - 1 - half) return period - 1 - half;
        return off;
    endfunction

endpackage

// File: rtl/setuphold_stim_gen_if.sv
// rtl/setuphold_stim_gen_if.sv - control, config, notifier and stimulus bundle of the stimulus generator
interface setuphold_stim_gen_if #(
    parameter int OFFW = 8,
    parameter int CNTW = 16
);
    logic            start;
    logic            abort;
    logic [CNTW-1:0] nframes;
    logic [OFFW-1:0] d_off;
    logic [OFFW-1:0] ti_off;
    logic [OFFW-1:0] te_off;
    logic            notifier;
    logic            cpo;
    logic            d_o;
    logic            ti_o;
    logic            te_o;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] viol_cnt;

    modport master (
        output start, abort, nframes, d_off, ti_off, te_off, notifier,
        input  cpo, d_o, ti_o, te_o, busy, done, viol_cnt
    );

    modport slave (
        input  start, abort, nframes, d_off, ti_off, te_off, notifier,
        output cpo, d_o, ti_o, te_o, busy, done, viol_cnt
    );
endinterface

// File: rtl/setuphold_stim_gen_stim_edge_sched.sv
// rtl/setuphold_stim_gen_stim_edge_sched.sv - one stimulus line toggling once per frame at EDGE+offset
module stim_edge_sched #(
    parameter int PERIOD = 64,
    parameter int TW     = 6,
    parameter bit INIT   = 1'b0
) (
    input  logic                CP,
    input  logic [TW-1:0]       tick,
    input  logic signed [TW:0]  off,
    input  logic                en,
    input  logic                load,
    input  logic                clear,
    output logic                q
);
    localparam int EDGE = PERIOD / 2;

    logic hit;

    always_comb begin
        hit = en && (int'(tick) == EDGE + int'(off));
    end

    always_ff @(posedge CP) begin
        if (clear) begin
            q <= 1'b0;
        end else if (load) begin
            q <= INIT;
        end else if (hit) begin
            q <= ~q;
        end
    end
endmodule

// File: rtl/setuphold_stim_gen.sv
// rtl/setuphold_stim_gen.sv - strobe clock, offset D/TI/TE stimulus and notifier violation counter
module setuphold_stim_gen
    import setuphold_stim_gen_pkg::*;
#(
    parameter int PERIOD = 64,
    parameter int OFFW   = 8,
    parameter int CNTW   = 16
) (
    input  logic                      CP,
    input  logic                      RST,
    setuphold_stim_gen_if.slave       sif
);
    localparam int EDGE = PERIOD / 2;
    localparam int TW   = $clog2(PERIOD);
    localparam int OW   = TW + 1;

    stim_state_e           state;
    stim_state_e           state_nxt;
    logic [TW-1:0]         tick;
    logic [CNTW-1:0]       frame;
    logic [CNTW-1:0]       nframes_q;
    logic signed [OW-1:0]  d_off_q;
    logic signed [OW-1:0]  ti_off_q;
    logic signed [OW-1:0]  te_off_q;
    logic                  notif_q;
    logic [CNTW-1:0]       viol_cnt;
    logic                  cpo_q;
    logic                  d_q;
    logic                  ti_q;
    logic                  te_q;

    logic start_ok;
    logic abort_ok;
    logic last_tick;
    logic run_end;
    logic viol_hit;
    logic line_clear;
    logic line_en;

    always_comb begin
        start_ok   = (state == IDLE) && sif.start && !sif.abort;
        abort_ok   = sif.abort && ((state == ARM) || (state == RUN));
        last_tick  = (tick == TW'(PERIOD - 1));
        run_end    = (state == RUN) && last_tick && (frame == nframes_q - CNTW'(1));
        viol_hit   = (state != IDLE) && (sif.notifier != notif_q);
        line_clear = RST || abort_ok;
        line_en    = (state == RUN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = ARM;
            ARM: begin
                if (sif.abort || (nframes_q == '0)) state_nxt = DONE;
                else                                state_nxt = RUN;
            end
            RUN:  if (sif.abort || run_end) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CP) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Config is latched only on an accepted start, so a start while busy leaves the run untouched.
    always_ff @(posedge CP) begin
        if (RST) begin
            nframes_q <= '0;
            d_off_q   <= '0;
            ti_off_q  <= '0;
            te_off_q  <= '0;
        end else if (start_ok) begin
            nframes_q <= sif.nframes;
            d_off_q   <= OW'(clamp_off(int'($signed(sif.d_off)), PERIOD));
            ti_off_q  <= OW'(clamp_off(int'($signed(sif.ti_off)), PERIOD));
            te_off_q  <= OW'(clamp_off(int'($signed(sif.te_off)), PERIOD));
        end
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            tick  <= '0;
            frame <= '0;
        end else if (state == ARM) begin
            tick  <= '0;
            frame <= '0;
        end else if (state == RUN) begin
            if (last_tick) begin
                tick  <= '0;
                frame <= frame + CNTW'(1);
            end else begin
                tick  <= tick + TW'(1);
            end
        end
    end

    // cpo follows the tick one cycle late, matching the registered stimulus lines.
    always_ff @(posedge CP) begin
        if (RST) cpo_q <= 1'b0;
        else     cpo_q <= (state == RUN) && !sif.abort && (tick >= TW'(EDGE));
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            notif_q  <= sif.notifier;
            viol_cnt <= '0;
        end else begin
            notif_q <= sif.notifier;
            if (start_ok) begin
                viol_cnt <= '0;
            end else if (viol_hit && (viol_cnt != '1)) begin
                viol_cnt <= viol_cnt + CNTW'(1);
            end
        end
    end

    stim_edge_sched #(.PERIOD(PERIOD), .TW(TW), .INIT(1'b0)) u_d (
        .CP(CP), .tick(tick), .off(d_off_q), .en(line_en),
        .load(start_ok), .clear(line_clear), .q(d_q)
    );

    stim_edge_sched #(.PERIOD(PERIOD), .TW(TW), .INIT(1'b1)) u_ti (
        .CP(CP), .tick(tick), .off(ti_off_q), .en(line_en),
        .load(start_ok), .clear(line_clear), .q(ti_q)
    );

    stim_edge_sched #(.PERIOD(PERIOD), .TW(TW), .INIT(1'b0)) u_te (
        .CP(CP), .tick(tick), .off(te_off_q), .en(line_en),
        .load(start_ok), .clear(line_clear), .q(te_q)
    );

    assign sif.cpo      = cpo_q;
    assign sif.d_o      = d_q;
    assign sif.ti_o     = ti_q;
    assign sif.te_o     = te_q;
    assign sif.busy     = (state == ARM) || (state == RUN);
    assign sif.done     = (state == DONE);
    assign sif.viol_cnt = viol_cnt;
endmodule

// File: tb/tb_setuphold_stim_gen.sv
// tb/tb_setuphold_stim_gen.sv - self-checking bench for setuphold_stim_gen
module tb_setuphold_stim_gen;
    localparam int P    = 64;
    localparam int EDGE = P / 2;

    logic cp;
    logic rst;
    int   checks;
    int   errors;

    setuphold_stim_gen_if #(.OFFW(8), .CNTW(16)) sif ();
    setuphold_stim_gen_if #(.OFFW(8), .CNTW(3))  sif_s ();

    setuphold_stim_gen #(.PERIOD(P), .OFFW(8), .CNTW(16)) dut (
        .CP(cp), .RST(rst), .sif(sif)
    );

    setuphold_stim_gen #(.PERIOD(8), .OFFW(8), .CNTW(3)) dut_s (
        .CP(cp), .RST(rst), .sif(sif_s)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    // Cycle k counts from 1 = first cycle after the start pulse; RUN spans k=2..1+n*P.
    function automatic int tgt(input int off);
        int c;
        c = off;
        if (c < -(EDGE - 1)) c = -(EDGE - 1);
        if (c > P - 1 - EDGE) c = P - 1 - EDGE;
        return EDGE + c;
    endfunction

    function automatic bit exp_line(input int k, input int n, input int t, input bit init);
        bit v;
        v = init;
        for (int f = 0; f < n; f++) begin
            if (2 + f * P + t < k) v = ~v;
        end
        return v;
    endfunction

    function automatic bit exp_cpo(input int k, input int n);
        if (k - 1 < 2 || k - 1 > 1 + n * P) return 1'b0;
        return ((k - 3) % P) >= EDGE;
    endfunction

    task automatic start_run(input int n, input int doff, input int tioff, input int teoff);
        @(negedge cp);
        sif.nframes = 16'(n);
        sif.d_off   = 8'(doff);
        sif.ti_off  = 8'(tioff);
        sif.te_off  = 8'(teoff);
        sif.start   = 1'b1;
        @(negedge cp);
        sif.start   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge cp);
        checks++;
        if ({sif.cpo, sif.d_o, sif.ti_o, sif.te_o, sif.busy, sif.done} !== 6'b0 || sif.viol_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_main got=%b viol=%0d exp=000000 viol=0",
                     {sif.cpo, sif.d_o, sif.ti_o, sif.te_o, sif.busy, sif.done}, sif.viol_cnt);
        end
        checks++;
        if ({sif_s.cpo, sif_s.busy, sif_s.done} !== 3'b0 || sif_s.viol_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_small got=%b viol=%0d exp=000 viol=0",
                     {sif_s.cpo, sif_s.busy, sif_s.done}, sif_s.viol_cnt);
        end
        rst = 1'b0;
        @(negedge cp);
    endtask

    task automatic test_run(input int n, input int doff, input int tioff, input int teoff);
        int td, tt, te_t;
        logic [5:0] got, exp;
        td   = tgt(doff);
        tt   = tgt(tioff);
        te_t = tgt(teoff);
        start_run(n, doff, tioff, teoff);
        for (int k = 1; k <= n * P + 4; k++) begin
            got = {sif.cpo, sif.d_o, sif.ti_o, sif.te_o, sif.busy, sif.done};
            exp = {exp_cpo(k, n), exp_line(k, n, td, 1'b0), exp_line(k, n, tt, 1'b1),
                   exp_line(k, n, te_t, 1'b0), (k <= 1 + n * P), (k == 2 + n * P)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run n=%0d off=%0d/%0d/%0d k=%0d {cpo,d,ti,te,busy,done} got=%b exp=%b",
                         n, doff, tioff, teoff, k, got, exp);
            end
            // Config churn and a stray start while busy must not disturb the run.
            sif.nframes = 16'($urandom);
            sif.d_off   = 8'($urandom);
            sif.ti_off  = 8'($urandom);
            sif.te_off  = 8'($urandom);
            sif.start   = (k == 5) && (k < 1 + n * P);
            @(negedge cp);
        end
        sif.start = 1'b0;
        checks++;
        if (sif.viol_cnt !== 16'd0) begin
            errors++;
            $display("FAIL run_viol got=%0d exp=0", sif.viol_cnt);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            test_run($urandom_range(0, 3), int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
    endtask

    task automatic test_viol;
        int nt;
        for (int it = 0; it < 2; it++) begin
            repeat (2) begin
                sif.notifier = ~sif.notifier;
                @(negedge cp);
            end
            nt = $urandom_range(1, 6);
            start_run(1, 0, 0, 0);
            for (int k = 1; k <= P + 4; k++) begin
                if (k >= 3 && k < 3 + nt) sif.notifier = ~sif.notifier;
                @(negedge cp);
            end
            checks++;
            if (sif.viol_cnt !== 16'(nt)) begin
                errors++;
                $display("FAIL viol_run it=%0d got=%0d exp=%0d", it, sif.viol_cnt, nt);
            end
            repeat (2) begin
                sif.notifier = ~sif.notifier;
                @(negedge cp);
            end
            checks++;
            if (sif.viol_cnt !== 16'(nt)) begin
                errors++;
                $display("FAIL viol_idle it=%0d got=%0d exp=%0d", it, sif.viol_cnt, nt);
            end
        end
    endtask

    task automatic test_saturate;
        int dones;
        dones = 0;
        @(negedge cp);
        sif_s.nframes = 3'd4;
        sif_s.start   = 1'b1;
        @(negedge cp);
        sif_s.start   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (sif_s.done) dones++;
            if (k <= 9) sif_s.notifier = ~sif_s.notifier;
            @(negedge cp);
        end
        checks++;
        if (sif_s.viol_cnt !== 3'd7) begin
            errors++;
            $display("FAIL saturate got=%0d exp=7", sif_s.viol_cnt);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL saturate_done got=%0d pulses exp=1", dones);
        end
    endtask

    task automatic test_abort;
        int ka;
        ka = 2 + P + 40;
        start_run(3, $urandom_range(0, 40) - 20, 20, -4);
        for (int k = 1; k <= ka; k++) begin
            checks++;
            if (sif.busy !== 1'b1 || sif.done !== 1'b0) begin
                errors++;
                $display("FAIL abort_busy k=%0d busy=%b done=%b exp busy=1 done=0", k, sif.busy, sif.done);
            end
            if (k == 20 || k == 30) sif.notifier = ~sif.notifier;
            sif.start = (k == 50);
            if (k == ka) sif.abort = 1'b1;
            @(negedge cp);
        end
        sif.abort = 1'b0;
        sif.start = 1'b0;
        checks++;
        if ({sif.cpo, sif.d_o, sif.ti_o, sif.te_o, sif.busy, sif.done} !== 6'b000001 || sif.viol_cnt !== 16'd2) begin
            errors++;
            $display("FAIL abort_done got=%b viol=%0d exp=000001 viol=2",
                     {sif.cpo, sif.d_o, sif.ti_o, sif.te_o, sif.busy, sif.done}, sif.viol_cnt);
        end
        @(negedge cp);
        checks++;
        if (sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.viol_cnt !== 16'd2) begin
            errors++;
            $display("FAIL abort_idle busy=%b done=%b viol=%0d exp 0 0 2", sif.busy, sif.done, sif.viol_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int kr, dones;
        kr    = 2 + 2 * P + 10;
        dones = 0;
        start_run(3, -10, 20, -4);
        for (int k = 1; k <= kr; k++) begin
            if (k == 10) sif.notifier = ~sif.notifier;
            if (k == kr) begin
                checks++;
                if (sif.viol_cnt !== 16'd1 || sif.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_pre viol=%0d busy=%b exp viol=1 busy=1", sif.viol_cnt, sif.busy);
                end
                rst = 1'b1;
            end
            @(negedge cp);
        end
        rst = 1'b0;
        checks++;
        if ({sif.cpo, sif.d_o, sif.ti_o, sif.te_o, sif.busy, sif.done} !== 6'b0 || sif.viol_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_state got=%b viol=%0d exp=000000 viol=0",
                     {sif.cpo, sif.d_o, sif.ti_o, sif.te_o, sif.busy, sif.done}, sif.viol_cnt);
        end
        for (int k = 0; k < 3 * P; k++) begin
            if (sif.done || sif.busy) dones++;
            @(negedge cp);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rstmid_nodone got=%0d busy/done cycles exp=0", dones);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sif.start = 1'b0;  sif.abort = 1'b0;  sif.nframes = '0;
        sif.d_off = '0;    sif.ti_off = '0;   sif.te_off = '0;  sif.notifier = 1'b0;
        sif_s.start = 1'b0; sif_s.abort = 1'b0; sif_s.nframes = '0;
        sif_s.d_off = '0;  sif_s.ti_off = '0; sif_s.te_off = '0; sif_s.notifier = 1'b0;

        test_reset();
        test_run(3, -10, 20, -4);
        test_run(2, -100, 100, 0);
        test_run(0, 3, -3, 7);
        test_run(2, 5, 5, 5);
        test_random();
        test_viol();
        test_saturate();
        test_abort();
        test_reset_mid();
        test_run(1, -31, 31, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
